// File: rtl/i2c_arbiter_pkg.sv
// Shared I2C driver constants: arbiter FSM encoding, idle byte and grant helpers.
// Imported by the arbiter top and its round-robin picker.
package i2c_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } arbState_t;

    localparam logic [7:0] ZERO8     = 8'h00;
    localparam logic [1:0] OWNER_RST = 2'd3;
    localparam logic [3:0] GNT_NONE  = 4'b0000;

    function automatic logic [3:0] oneHot4(input logic [1:0] idx);
        oneHot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/i2c_arbiter_rr_pick.sv
// Round-robin picker: first set request after the pointer, wrapping modulo 4.
// The pointer itself has the lowest priority.
module i2c_rr_pick
    import i2c_arbiter_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] idx,
    output logic       valid
);

    logic [1:0] cand_s;

    // Scan from farthest to nearest so the nearest set request after ptr wins
    always_comb begin
        idx    = ptr;
        valid  = 1'b0;
        cand_s = ptr;
        for (int i = 4; i >= 1; i--) begin
            cand_s = ptr + 2'(i);
            if (req[cand_s]) begin
                idx   = cand_s;
                valid = 1'b1;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master among four requesters.
// Grant, owner and timeout are registered; master-side controls are muxed from the grantee.
module i2c_arbiter
    import i2c_arbiter_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = 16'hFFFF,
    parameter int          NREQ    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   start_in,
    input  logic [NREQ-1:0]   send_in,
    input  logic [NREQ-1:0]   receive_in,
    input  logic [NREQ*8-1:0] datasend_in,
    input  logic              isReady,
    input  logic              sended,
    input  logic              received,
    input  logic [7:0]        datareceive,
    output logic              start,
    output logic              send,
    output logic              receive,
    output logic [7:0]        datasend,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   sended_out,
    output logic [NREQ-1:0]   received_out,
    output logic [NREQ-1:0]   ready_out,
    output logic [7:0]        datareceive_out,
    output logic [1:0]        owner,
    output logic              timeout
);

    arbState_t   state_r, nextState_s;
    logic [3:0]  gnt_r, gntNext_s;
    logic [1:0]  owner_r, ownerNext_s;
    logic [15:0] waitCnt_r, cntNext_s;
    logic        timeout_r, timeoutNext_s;
    logic [1:0]  pickIdx_s;
    logic        pickValid_s;

    i2c_rr_pick u_pick (
        .req   (req),
        .ptr   (owner_r),
        .idx   (pickIdx_s),
        .valid (pickValid_s)
    );

    // Next-state and next-register values; the master going busy outranks a request drop
    always_comb begin
        nextState_s   = state_r;
        gntNext_s     = gnt_r;
        ownerNext_s   = owner_r;
        cntNext_s     = waitCnt_r;
        timeoutNext_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (isReady && pickValid_s) begin
                    nextState_s = GRANT;
                    gntNext_s   = oneHot4(pickIdx_s);
                    ownerNext_s = pickIdx_s;
                    cntNext_s   = 16'h0000;
                end else begin
                    gntNext_s = GNT_NONE;
                end
            end
            GRANT: begin
                if (!isReady) begin
                    nextState_s = BUSY;
                end else if (!req[owner_r]) begin
                    nextState_s = RELEASE;
                    gntNext_s   = GNT_NONE;
                end else if (waitCnt_r == TIMEOUT - 16'd1) begin
                    // The TIMEOUT-th GRANT cycle ends the wait
                    nextState_s   = RELEASE;
                    gntNext_s     = GNT_NONE;
                    timeoutNext_s = 1'b1;
                end else begin
                    cntNext_s = waitCnt_r + 16'd1;
                end
            end
            BUSY: begin
                if (isReady) begin
                    nextState_s = RELEASE;
                    gntNext_s   = GNT_NONE;
                end else begin
                    nextState_s = BUSY;
                end
            end
            RELEASE: begin
                nextState_s = IDLE;
                gntNext_s   = GNT_NONE;
            end
            default: begin
                nextState_s = IDLE;
                gntNext_s   = GNT_NONE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= IDLE;
            gnt_r     <= GNT_NONE;
            owner_r   <= OWNER_RST;
            waitCnt_r <= 16'h0000;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= nextState_s;
            gnt_r     <= gntNext_s;
            owner_r   <= ownerNext_s;
            waitCnt_r <= cntNext_s;
            timeout_r <= timeoutNext_s;
        end
    end

    // Master-side mux: only the grantee drives the master while it holds the grant
    always_comb begin
        start    = 1'b0;
        send     = 1'b0;
        receive  = 1'b0;
        datasend = ZERO8;
        if (state_r == GRANT || state_r == BUSY) begin
            start    = start_in[owner_r];
            send     = send_in[owner_r];
            receive  = receive_in[owner_r];
            datasend = datasend_in[{owner_r, 3'b000} +: 8];
        end else begin
            datasend = ZERO8;
        end
    end

    assign gnt             = gnt_r;
    assign owner           = owner_r;
    assign timeout         = timeout_r;
    assign sended_out      = gnt_r & {NREQ{sended}};
    assign received_out    = gnt_r & {NREQ{received}};
    assign ready_out       = gnt_r & {NREQ{isReady}};
    assign datareceive_out = datareceive;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Self-checking bench for i2c_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level holder/gap model.
module tb_i2c_arbiter;

    localparam logic [15:0] TO = 16'h0010;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req, start_in, send_in, receive_in;
    logic [31:0] datasend_in;
    logic        isReady, sended, received;
    logic [7:0]  datareceive;
    logic        start, send, receive, timeout;
    logic [7:0]  datasend, datareceive_out;
    logic [3:0]  gnt, sended_out, received_out, ready_out;
    logic [1:0]  owner;

    int checks = 0;
    int failures = 0;

    i2c_arbiter #(.TIMEOUT(TO), .NREQ(4)) dut (
        .clk(clk), .reset(reset), .req(req), .start_in(start_in), .send_in(send_in),
        .receive_in(receive_in), .datasend_in(datasend_in), .isReady(isReady),
        .sended(sended), .received(received), .datareceive(datareceive),
        .start(start), .send(send), .receive(receive), .datasend(datasend), .gnt(gnt),
        .sended_out(sended_out), .received_out(received_out), .ready_out(ready_out),
        .datareceive_out(datareceive_out), .owner(owner), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Reference model: who holds the master, whether the master went busy,
    // how long the holder has waited, and the forced idle gap after a release.
    int mHolder = -1;
    int mPtr    = 3;
    int mGap    = 0;
    int mWait   = 0;
    bit mBusy   = 1'b0;
    bit mTo     = 1'b0;

    always @(posedge clk) begin
        mTo = 1'b0;
        if (reset !== 1'b1) begin
            mHolder = -1; mPtr = 3; mGap = 0; mWait = 0; mBusy = 1'b0;
        end else if (mHolder >= 0) begin
            if (mBusy) begin
                if (isReady) begin mHolder = -1; mGap = 1; end
            end else if (!isReady) begin
                mBusy = 1'b1;
            end else if (!req[mHolder]) begin
                mHolder = -1; mGap = 1;
            end else if (mWait + 1 == int'(TO)) begin
                mHolder = -1; mGap = 1; mTo = 1'b1;
            end else begin
                mWait++;
            end
        end else if (mGap > 0) begin
            mGap--;
        end else if (isReady && req != 4'b0000) begin
            for (int k = 1; k <= 4; k++)
                if (mHolder < 0 && req[(mPtr + k) % 4]) mHolder = (mPtr + k) % 4;
            mPtr = mHolder; mWait = 0; mBusy = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idleInputs();
        req = 4'b0000; start_in = 4'b0000; send_in = 4'b0000; receive_in = 4'b0000;
        datasend_in = 32'h0000_0000; isReady = 1'b0; sended = 1'b0; received = 1'b0;
        datareceive = 8'h00;
    endtask

    task automatic doReset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idleInputs();
        doReset();
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if (owner !== 2'd3) begin failures++; $display("FAIL reset_owner got=%0d exp=3", owner); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        checks++; if (datasend !== 8'h00) begin failures++; $display("FAIL reset_datasend got=%h exp=00", datasend); end
    endtask

    task automatic test_single();
        idleInputs();
        doReset();
        isReady = 1'b1; req = 4'b0001; datasend_in = 32'h1234_56EA; start_in = 4'b0001;
        tick();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
        checks++; if (datasend !== 8'hEA) begin failures++; $display("FAIL single_datasend got=%h exp=EA", datasend); end
        checks++; if (start !== 1'b1) begin failures++; $display("FAIL single_start got=%b exp=1", start); end
        isReady = 1'b0;
        tick();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL single_busy_gnt got=%b exp=0001", gnt); end
        isReady = 1'b1;
        tick();
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL single_release_gnt got=%b exp=0000", gnt); end
        checks++; if (datasend !== 8'h00) begin failures++; $display("FAIL single_release_ds got=%h exp=00", datasend); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL single_timeout got=%b exp=0", timeout); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        int n;
        idleInputs();
        doReset();
        req = 4'b1111; isReady = 1'b1;
        for (int t = 0; t < 5; t++) begin
            exp = 4'b0001 << (t % 4);
            n = 0;
            while (gnt === 4'b0000 && n < 10) begin tick(); n++; end
            checks++; if (gnt !== exp) begin failures++; $display("FAIL rr_order_%0d got=%b exp=%b", t, gnt, exp); end
            isReady = 1'b0;
            tick();
            isReady = 1'b1;
            tick();
        end
    endtask

    task automatic test_timeout();
        int n;
        idleInputs();
        doReset();
        req = 4'b0010; isReady = 1'b1;
        tick();
        checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL to_grant got=%b exp=0010", gnt); end
        n = 0;
        while (timeout !== 1'b1 && n < 40) begin tick(); n++; end
        checks++; if (n != 16) begin failures++; $display("FAIL to_delay got=%0d exp=16", n); end
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL to_gnt got=%b exp=0000", gnt); end
        tick();
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL to_pulse got=%b exp=0", timeout); end
        req = 4'b0000;
    endtask

    task automatic test_routing();
        idleInputs();
        doReset();
        req = 4'b0100; isReady = 1'b1; datareceive = 8'h5C;
        tick();
        checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL route_gnt got=%b exp=0100", gnt); end
        checks++; if (ready_out !== 4'b0100) begin failures++; $display("FAIL route_ready got=%b exp=0100", ready_out); end
        isReady = 1'b0;
        tick();
        sended = 1'b1; received = 1'b1; start_in = 4'b1011;
        #1;
        checks++; if (sended_out !== 4'b0100) begin failures++; $display("FAIL route_sended got=%b exp=0100", sended_out); end
        checks++; if (received_out !== 4'b0100) begin failures++; $display("FAIL route_received got=%b exp=0100", received_out); end
        checks++; if (start !== 1'b0) begin failures++; $display("FAIL route_start_iso got=%b exp=0", start); end
        checks++; if (datareceive_out !== 8'h5C) begin failures++; $display("FAIL route_drx got=%h exp=5C", datareceive_out); end
        start_in = 4'b0100;
        #1;
        checks++; if (start !== 1'b1) begin failures++; $display("FAIL route_start got=%b exp=1", start); end
        sended = 1'b0; received = 1'b0; isReady = 1'b1; req = 4'b0000;
        tick();
    endtask

    task automatic test_early_drop();
        idleInputs();
        doReset();
        req = 4'b1001; isReady = 1'b1;
        tick();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL drop_grant got=%b exp=0001", gnt); end
        req = 4'b1000;
        tick();
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL drop_release got=%b exp=0000", gnt); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL drop_timeout got=%b exp=0", timeout); end
        tick();
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL drop_gap got=%b exp=0000", gnt); end
        tick();
        checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL drop_next got=%b exp=1000", gnt); end
        checks++; if (owner !== 2'd3) begin failures++; $display("FAIL drop_owner got=%0d exp=3", owner); end
    endtask

    task automatic test_reset_busy();
        idleInputs();
        doReset();
        req = 4'b0001; isReady = 1'b1;
        tick();
        isReady = 1'b0; start_in = 4'b1111; send_in = 4'b1111; receive_in = 4'b1111;
        datasend_in = 32'hA5A5_A5A5;
        tick();
        checks++; if (send !== 1'b1) begin failures++; $display("FAIL rbusy_pre_send got=%b exp=1", send); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL rbusy_gnt got=%b exp=0000", gnt); end
        checks++; if ({start, send, receive} !== 3'b000) begin failures++; $display("FAIL rbusy_ctl got=%b exp=000", {start, send, receive}); end
        checks++; if (datasend !== 8'h00) begin failures++; $display("FAIL rbusy_ds got=%h exp=00", datasend); end
        checks++; if (owner !== 2'd3) begin failures++; $display("FAIL rbusy_owner got=%0d exp=3", owner); end
    endtask

    task automatic test_random();
        logic [3:0] eg, er, esd, erc;
        logic [7:0] eds;
        logic [2:0] ectl;
        idleInputs();
        doReset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            isReady = ($urandom_range(0, 9) < 7);
            start_in = 4'($urandom); send_in = 4'($urandom); receive_in = 4'($urandom);
            datasend_in = $urandom; sended = 1'($urandom); received = 1'($urandom);
            datareceive = 8'($urandom);
            reset = ($urandom_range(0, 199) != 0);
            #1;
            eg   = (mHolder >= 0) ? (4'b0001 << mHolder) : 4'b0000;
            er   = eg & {4{isReady}};
            esd  = eg & {4{sended}};
            erc  = eg & {4{received}};
            eds  = (mHolder >= 0) ? datasend_in[mHolder * 8 +: 8] : 8'h00;
            ectl = (mHolder >= 0) ? {start_in[mHolder], send_in[mHolder], receive_in[mHolder]} : 3'b000;
            checks++; if (gnt !== eg) begin failures++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, gnt, eg); end
            checks++; if (owner !== 2'(mPtr)) begin failures++; $display("FAIL rnd_owner c=%0d got=%0d exp=%0d", c, owner, mPtr); end
            checks++; if (timeout !== mTo) begin failures++; $display("FAIL rnd_timeout c=%0d got=%b exp=%b", c, timeout, mTo); end
            checks++; if ({start, send, receive} !== ectl) begin failures++; $display("FAIL rnd_ctl c=%0d got=%b exp=%b", c, {start, send, receive}, ectl); end
            checks++; if (datasend !== eds) begin failures++; $display("FAIL rnd_ds c=%0d got=%h exp=%h", c, datasend, eds); end
            checks++; if ({ready_out, sended_out, received_out} !== {er, esd, erc}) begin
                failures++; $display("FAIL rnd_route c=%0d got=%b exp=%b", c, {ready_out, sended_out, received_out}, {er, esd, erc});
            end
            checks++; if (datareceive_out !== datareceive) begin failures++; $display("FAIL rnd_drx c=%0d got=%h exp=%h", c, datareceive_out, datareceive); end
            tick();
        end
        reset = 1'b1;
    endtask

    initial begin
        idleInputs();
        reset = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_routing();
        test_early_drop();
        test_reset_busy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
